// File: rtl/imem_loader_if.sv
// imem_loader_if -- bus bundle between the program loader and the core.
//   Load side : load_valid, load_data[7:0], load_last in; load_ready out.
//   Fetch side: program_counter[31:0] in; instruction[INSTR_WIDTH-1:0] out.
//   master modport drives the byte stream and program counter.
//   slave modport is the memory/loader side.
interface imem_loader_if #(
   parameter int INSTR_WIDTH = 32
);
   logic                   load_valid;
   logic [7:0]             load_data;
   logic                   load_last;
   logic                   load_ready;
   logic [31:0]            program_counter;
   logic [INSTR_WIDTH-1:0] instruction;

   modport master (
      output load_valid, load_data, load_last, program_counter,
      input  load_ready, instruction
   );

   modport slave (
      input  load_valid, load_data, load_last, program_counter,
      output load_ready, instruction
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- instruction memory with a byte-stream program loader.
// Bytes are packed little-endian into words and written to memory. The core
// is held in reset until the program is complete, after which the memory
// serves instruction = mem[program_counter] combinationally.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          imem_loader_if.slave (load stream + fetch port)
//   core_rst     reset to the core, high until the program is loaded
//   load_done    program loaded, memory serving
//   words_loaded number of valid words written
module imem_loader #(
   parameter int                     DEPTH       = 18,
   parameter int                     INSTR_WIDTH = 32,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
   input  logic                         clk,
   input  logic                         rst,
   imem_loader_if.slave                 bus,
   output logic                         core_rst,
   output logic                         load_done,
   output logic [$clog2(DEPTH+1)-1:0]   words_loaded
);
   localparam int WCW = $clog2(DEPTH + 1);
   localparam int AW  = $clog2(DEPTH);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [1:0]             byte_cnt;
   logic [WCW-1:0]         word_cnt;
   logic [INSTR_WIDTH-1:0] shift_reg;
   logic [INSTR_WIDTH-1:0] word_asm;
   logic [INSTR_WIDTH-1:0] mem [0:DEPTH-1];
   logic                   accept;
   logic                   word_wr;
   logic                   finish;

   // Accept depends on the state register only, so no loop through load_ready.
   assign accept = bus.load_valid && (state == LOAD);

   // shift_reg is cleared after every word write, so lanes above byte_cnt are
   // already zero; OR-ing in the incoming byte gives a zero-padded partial word.
   assign word_asm = shift_reg | (INSTR_WIDTH'(bus.load_data) << {byte_cnt, 3'b000});

   // A word is written on its 4th byte or on a short final word.
   assign word_wr = accept && ((byte_cnt == 2'd3) || bus.load_last);

   // Full-word completion of the last slot and load_last both end the load;
   // together they still produce a single write and a single transition.
   assign finish = accept &&
                   (bus.load_last || ((byte_cnt == 2'd3) && (word_cnt == WCW'(DEPTH - 1))));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         byte_cnt  <= 2'd0;
         word_cnt  <= '0;
         shift_reg <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            if (word_wr) begin
               byte_cnt  <= 2'd0;
               shift_reg <= '0;
               word_cnt  <= word_cnt + 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               shift_reg[{byte_cnt, 3'b000} +: 8] <= bus.load_data;
            end
         end
      end
   end

   // Memory contents are not reset; words_loaded masks stale entries.
   always_ff @(posedge clk) begin
      if (!rst && word_wr) begin
         mem[word_cnt[AW-1:0]] <= word_asm;
      end
   end

   always_comb begin
      state_next     = state;
      bus.load_ready = 1'b0;
      core_rst       = 1'b0;
      load_done      = 1'b0;
      case (state)
         LOAD: begin
            bus.load_ready = 1'b1;
            core_rst       = 1'b1;
            if (finish) begin
               state_next = RUN;
            end
         end
         RUN: begin
            load_done = 1'b1;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // Full 32-bit compare rejects PCs with nonzero upper bits before indexing.
   always_comb begin
      bus.instruction = NOP_INSTR;
      if ((state == RUN) && (bus.program_counter < 32'(word_cnt))) begin
         bus.instruction = mem[bus.program_counter[AW-1:0]];
      end
   end

   assign words_loaded = word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- scoreboard bench for imem_loader. Stimulus pushes
// expected observations into a queue; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_imem_loader;
   localparam int DEPTH = 18;
   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam int K_INSTR = 0;
   localparam int K_WORDS = 1;
   localparam int K_CRST  = 2;
   localparam int K_DONE  = 3;
   localparam int K_READY = 4;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   logic core_rst;
   logic load_done;
   logic [$clog2(DEPTH+1)-1:0] words_loaded;

   imem_loader_if #(.INSTR_WIDTH(32)) bus ();

   imem_loader #(.DEPTH(DEPTH), .INSTR_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .core_rst     (core_rst),
      .load_done    (load_done),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // Monitor: every queued expectation is checked on the next falling edge.
   exp_t        it;
   logic [31:0] act;
   always @(negedge clk) begin
      while (q.size() > 0) begin
         it = q.pop_front();
         case (it.kind)
            K_INSTR: act = bus.instruction;
            K_WORDS: act = 32'(words_loaded);
            K_CRST:  act = 32'(core_rst);
            K_DONE:  act = 32'(load_done);
            default: act = 32'(bus.load_ready);
         endcase
         n_checks = n_checks + 1;
         if (act !== it.exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
         end
      end
   end

   function automatic void expect_val(string nm, int kind, logic [31:0] e);
      exp_t x;
      x.name = nm;
      x.kind = kind;
      x.exp  = e;
      q.push_back(x);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      bus.load_last  = last;
      step();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
   endtask

   task automatic check_pc(string nm, input logic [31:0] pc, input logic [31:0] e);
      bus.program_counter = pc;
      expect_val(nm, K_INSTR, e);
      step();
   endtask

   function automatic logic [31:0] prog_word(input int k);
      return 32'h0000_0093 + (32'(k) << 20);
   endfunction

   // Stream the 18-word program; gap inserts an idle cycle before each byte.
   task automatic stream_full(input bit gap, input string tag);
      logic [31:0] w;
      for (int b = 0; b < 4 * DEPTH; b++) begin
         w = prog_word(b / 4);
         if (gap) begin
            bus.load_valid = 1'b0;
            step();
         end
         if (b == 4 * DEPTH - 1) begin
            expect_val({tag, "_crst_before_last"}, K_CRST, 32'd1);
            expect_val({tag, "_done_before_last"}, K_DONE, 32'd0);
            expect_val({tag, "_ready_before_last"}, K_READY, 32'd1);
         end
         send_byte(w[(b % 4) * 8 +: 8], 1'b0);
      end
      expect_val({tag, "_crst_after"}, K_CRST, 32'd0);
      expect_val({tag, "_done_after"}, K_DONE, 32'd1);
      expect_val({tag, "_ready_after"}, K_READY, 32'd0);
      expect_val({tag, "_words"}, K_WORDS, 32'd18);
      step();
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      bus.load_last  = 1'b0;
      bus.program_counter = 32'd0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      expect_val("rst_crst", K_CRST, 32'd1);
      expect_val("rst_ready", K_READY, 32'd1);
      expect_val("rst_done", K_DONE, 32'd0);
      expect_val("rst_words", K_WORDS, 32'd0);
      check_pc("rst_instr", 32'd0, NOP);

      // Full 18-word program, back to back
      stream_full(1'b0, "full");
      check_pc("full_pc5", 32'd5, 32'h0050_0093);
      check_pc("full_pc0", 32'd0, 32'h0000_0093);
      check_pc("full_pc17", 32'd17, 32'h0110_0093);
      check_pc("full_pc18", 32'd18, NOP);

      // Reset from RUN, then 3 words with load_last on byte 12
      do_reset();
      expect_val("rerun_crst", K_CRST, 32'd1);
      expect_val("rerun_words", K_WORDS, 32'd0);
      check_pc("rerun_pc0", 32'd0, NOP);
      for (int b = 0; b < 12; b++) begin
         w = prog_word(b / 4);
         send_byte(w[(b % 4) * 8 +: 8], (b == 11));
      end
      expect_val("w3_words", K_WORDS, 32'd3);
      expect_val("w3_done", K_DONE, 32'd1);
      check_pc("w3_pc2", 32'd2, 32'h0020_0093);
      check_pc("w3_pc3", 32'd3, NOP);
      check_pc("w3_pc17", 32'd17, NOP);

      // Partial final word: AA BB CC DD EE(last)
      do_reset();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
      send_byte(8'hEE, 1'b1);
      expect_val("part_words", K_WORDS, 32'd2);
      expect_val("part_crst", K_CRST, 32'd0);
      check_pc("part_pc0", 32'd0, 32'hDDCC_BBAA);
      check_pc("part_pc1", 32'd1, 32'h0000_00EE);

      // Gapped stream gives the same result
      do_reset();
      stream_full(1'b1, "gap");
      check_pc("gap_pc5", 32'd5, 32'h0050_0093);
      check_pc("gap_pc11", 32'd11, 32'h00B0_0093);

      // Reset after 40 bytes, coinciding with an offered byte
      do_reset();
      for (int b = 0; b < 40; b++) begin
         w = prog_word(b / 4);
         send_byte(w[(b % 4) * 8 +: 8], 1'b0);
      end
      rst = 1'b1;
      send_byte(8'h5A, 1'b0);
      rst = 1'b0;
      expect_val("mid_crst", K_CRST, 32'd1);
      expect_val("mid_words", K_WORDS, 32'd0);
      check_pc("mid_pc0", 32'd0, NOP);
      send_byte(8'h13, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h00, 1'b1);
      expect_val("reload_words", K_WORDS, 32'd1);
      expect_val("reload_done", K_DONE, 32'd1);
      check_pc("reload_pc0", 32'd0, 32'h0010_0113);
      check_pc("reload_pc1", 32'd1, NOP);

      // RUN ignores the load stream
      for (int c = 0; c < 20; c++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 8'($urandom_range(0, 255));
         bus.load_last  = 1'($urandom_range(0, 1));
         if (c % 5 == 0) expect_val("run_ready", K_READY, 32'd0);
         step();
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      expect_val("run_words", K_WORDS, 32'd1);
      expect_val("run_done", K_DONE, 32'd1);
      check_pc("run_pc0", 32'd0, 32'h0010_0113);
      check_pc("run_pcmax", 32'hFFFF_FFFF, NOP);
      check_pc("run_pc_upper", 32'h0001_0000, NOP);

      step();
      if (q.size() != 0) begin
         n_checks = n_checks + 1;
         n_fails  = n_fails + 1;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-side responder for the RV32I single-cycle core.
- Receives a program as a byte stream, packs it little-endian into 32-bit words and stores it.
- Holds the core in reset while the program loads, then serves instruction = mem[program_counter] combinationally each cycle.
- Replaces the bench-side program array with a synthesizable program memory and loader.

Parameters:
- DEPTH, 18, number of 32-bit instruction words stored (program counter is a word index).
- INSTR_WIDTH, 32, instruction word width.
- NOP_INSTR, 32'h0000_0013, value returned for unloaded or out-of-range addresses (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load byte valid.
- load_data  in  8  load byte; the first byte of each word is the LSB.
- load_last  in  1  qualifies the final byte of the program; sampled only on an accepted byte.
- load_ready  out  1  loader accepts a byte this cycle.
- program_counter  in  32  word index from the core.
- instruction  out  INSTR_WIDTH  instruction for the current program_counter.
- core_rst  out  1  reset to the core; high until the program is loaded.
- load_done  out  1  program loaded, memory serving.
- words_loaded  out  $clog2(DEPTH+1)  number of valid words written.

Behaviour:
- FSM states: LOAD and RUN. Reset enters LOAD.
- Reset values: byte_cnt=0, word_cnt=0, shift register=0, load_ready=1, core_rst=1, load_done=0, words_loaded=0. Memory array is not cleared.
- LOAD state:
  - load_ready=1. A byte is accepted when load_valid && load_ready.
  - Each accepted byte goes into lane byte_cnt of the shift register, and byte_cnt increments.
  - When the 4th byte is accepted (byte_cnt==3), the assembled word is written to mem[word_cnt] on that edge, word_cnt increments, and byte_cnt wraps to 0.
- LOAD -> RUN, on the edge that accepts either of:
  - the byte completing word index DEPTH-1; or
  - any byte with load_last=1.
- load_last on a partial word (byte_cnt<3): unfilled upper bytes are written as 0. The partial word counts as loaded.
- load_last on a byte that completes word DEPTH-1 gives one transition, with no double count.
- RUN state:
  - load_ready=0, load_done=1, core_rst=0.
  - These are registered from state, so core_rst falls the cycle after the final byte is accepted.
  - No further writes. load_valid is ignored.
- Serving:
  - instruction is combinational: mem[program_counter] when state==RUN and program_counter < words_loaded.
  - Otherwise instruction=NOP_INSTR. This covers LOAD state, PC >= words_loaded, PC >= DEPTH, and PC with nonzero upper bits.
- Full/empty boundaries:
  - words_loaded saturates at DEPTH; a word write beyond index DEPTH-1 is impossible by construction.
  - If load_last is never asserted and fewer than DEPTH words arrive, the block stays in LOAD indefinitely with core_rst=1.
- Reset mid-operation, in either state:
  - Next edge returns to LOAD with counters zeroed; the partial word is discarded.
  - words_loaded=0 masks stale memory contents, so all reads give NOP_INSTR.
  - core_rst reasserts on that edge.
- Simultaneous rst and an accepted byte: rst wins and the byte is dropped.

Test Plan:
- Reset then stream 18 words (72 bytes, word k = 32'h0000_0093 + (k<<20)), load_last=0 throughout -> load_done/core_rst toggle one cycle after byte 72. words_loaded=18. PC=5 gives 32'h0050_0093.
- Load 3 words, with load_last on byte 12 -> words_loaded=3. PC=2 gives word 2. PC=3 and PC=17 give 32'h0000_0013.
- Load 5 bytes AA,BB,CC,DD,EE with load_last on EE -> mem[1]=32'h0000_00EE, words_loaded=2, RUN entered.
- load_valid toggling every other cycle during load -> identical final contents and words_loaded as the back-to-back case. load_ready stays 1 until the final accepted byte.
- Assert rst after 40 bytes of a 72-byte stream, then reload 1 word 32'h0010_0113 with load_last -> words_loaded=1. PC=0 gives 32'h0010_0113. PC=1 gives NOP (no stale data).
- In RUN, drive load_valid=1 with random data for 20 cycles -> memory unchanged, load_ready=0. PC=32'hFFFF_FFFF gives NOP.
